// File: rtl/apb_master_bridge.sv
// APB (AMBA3) master bridge: local single-cycle requests -> APB SETUP/ACCESS.
// Optional `define APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  trans_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wr_rd_i,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  trans_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
`endif

    // Single FSM: sequences SETUP/ACCESS and registers every bus/requester output.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rdata_o     <= '0;
            trans_err_o <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            trans_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trans_i) begin
                        state   <= SETUP;
                        pselx   <= 1'b1;
                        penable <= 1'b0;
                        paddr   <= addr_i;
                        pwrite  <= wr_rd_i;
                        if (wr_rd_i) begin
                            pwdata <= wdata_i;
                        end
`ifdef APB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    pselx   <= 1'b1;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        if (!pwrite) begin
                            rdata_o <= prdata;
                        end
                        trans_err_o <= pslverr;
                        if (trans_i) begin
                            // back-to-back: skip IDLE, pselx stays high
                            state   <= SETUP;
                            penable <= 1'b0;
                            paddr   <= addr_i;
                            pwrite  <= wr_rd_i;
                            if (wr_rd_i) begin
                                pwdata <= wdata_i;
                            end
`ifdef APB_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            state   <= IDLE;
                            pselx   <= 1'b0;
                            penable <= 1'b0;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        // slave never answered: drop transfer, flag error
                        trans_err_o <= 1'b1;
                        state       <= IDLE;
                        pselx       <= 1'b0;
                        penable     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    pselx   <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: driver pushes expected completions,
// monitor pops and compares whenever an APB transfer ends.
module tb_apb_master_bridge;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        logic        b2b;
    } txn_t;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        abort;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset;
    logic        trans_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic        wr_rd_i;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] rdata_o;
    logic        trans_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    txn_t txns[$];
    exp_t sb[$];

    // model of what the requester should see
    logic [31:0] m_rdata = '0;
    logic [31:0] m_wdata = '0;

    apb_master_bridge dut (
        .pclk(pclk), .preset(preset), .trans_i(trans_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .wr_rd_i(wr_rd_i),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .pselx(pselx), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .rdata_o(rdata_o),
        .trans_err_o(trans_err_o)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic present(input txn_t t);
        trans_i = 1'b1;
        addr_i  = t.addr;
        wdata_i = t.wdata;
        wr_rd_i = t.wr;
    endtask

    task automatic scramble();
        trans_i = 1'($urandom);
        addr_i  = 8'($urandom);
        wdata_i = $urandom;
        wr_rd_i = 1'($urandom);
    endtask

    task automatic push_exp(input txn_t t, input logic abort);
        exp_t e;
        if (t.wr) m_wdata = t.wdata;
        else if (!abort) m_rdata = t.rdata;
        e.addr  = t.addr;
        e.wr    = t.wr;
        e.wdata = m_wdata;
        e.rdata = m_rdata;
        e.err   = t.err;
        e.abort = abort;
        sb.push_back(e);
    endtask

    task automatic add(input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input int w, input logic err,
                       input logic [31:0] rd, input logic b2b);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = d; t.waits = w;
        t.err = err; t.rdata = rd; t.b2b = b2b;
        txns.push_back(t);
    endtask

    task automatic run_list();
        bit presented = 0;
        for (int i = 0; i < txns.size(); i++) begin
            txn_t t;
            int   acc;
            int   guard;
            t = txns[i];
            if (!presented) begin
                @(negedge pclk);
                present(t);
            end
            presented = 0;
            guard = 0;
            forever begin
                @(negedge pclk);
                if (pselx && penable) break;
                scramble();
                guard++;
                if (guard > 8) begin
                    fail_now("wait_access_timeout");
                    break;
                end
            end
            acc = 1;
            for (int w = 0; w < t.waits; w++) begin
                scramble();
                @(negedge pclk);
                if (pselx && penable) acc++;
            end
            pready  = 1'b1;
            pslverr = t.err;
            prdata  = t.rdata;
            if (t.b2b && i + 1 < txns.size()) begin
                present(txns[i+1]);
                presented = 1;
            end else begin
                trans_i = 1'b0;
            end
            push_exp(t, 1'b0);
            @(negedge pclk);
            check("access_len", 64'(acc), 64'(t.waits + 1));
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = $urandom;
            if (presented) begin
                check("b2b_setup", {pselx, penable}, 2'b10);
            end else begin
                check("idle_after", {pselx, penable}, 2'b00);
                repeat ($urandom_range(0, 2)) @(negedge pclk);
            end
        end
        txns.delete();
    endtask

    // Monitor: detects transfer ends on the bus and compares against the scoreboard.
    initial begin
        logic       p_sel = 1'b0;
        logic       p_en  = 1'b0;
        logic       p_wr  = 1'b0;
        logic [7:0] p_addr = '0;
        logic [31:0] p_wd = '0;
        exp_t       e;
        forever begin
            @(posedge pclk);
            #1;
            if (preset) begin
                check("reset_ctrl", {pselx, penable, pwrite, trans_err_o}, 0);
                check("reset_paddr", paddr, 0);
                check("reset_pwdata", pwdata, 0);
                check("reset_rdata", rdata_o, 0);
            end else begin
                if (p_sel && p_en && (pready || !penable)) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_completion");
                    end else begin
                        e = sb.pop_front();
                        check("paddr", p_addr, e.addr);
                        check("pwrite", p_wr, e.wr);
                        check("pwdata", p_wd, e.wdata);
                        check("rdata_o", rdata_o, e.rdata);
                        check("trans_err_o", trans_err_o, e.err);
                        check("abort", !pready, e.abort);
                    end
                end else begin
                    check("err_quiet", trans_err_o, 1'b0);
                end
                if (p_sel && !p_en)
                    check("setup_to_access", {pselx, penable}, 2'b11);
            end
            p_sel  = pselx;
            p_en   = penable;
            p_wr   = pwrite;
            p_addr = paddr;
            p_wd   = pwdata;
        end
    end

    // Driver: directed cases, random traffic, mid-transfer reset.
    initial begin
        txn_t t;
        int   acc;
        preset  = 1'b1;
        trans_i = 1'b1;
        addr_i  = 8'hAA;
        wdata_i = 32'h55AA55AA;
        wr_rd_i = 1'b1;
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hFFFFFFFF;
        repeat (2) @(negedge pclk);
        preset  = 1'b0;
        trans_i = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        @(negedge pclk);
        check("idle_after_reset", {pselx, penable}, 2'b00);

        add(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b0);
        add(1'b0, 8'h10, 32'h11111111, 3, 1'b0, 32'hDEADBEEF, 1'b0);
        add(1'b0, 8'hFF, 32'h22222222, 0, 1'b1, 32'h12345678, 1'b0);
        add(1'b1, 8'h01, 32'hA0A0A0A0, 0, 1'b0, 32'h0, 1'b1);
        add(1'b1, 8'h02, 32'hB0B0B0B0, 1, 1'b0, 32'h0, 1'b0);
        run_list();

        // reset in the middle of ACCESS drops the transfer silently
        @(negedge pclk);
        t.wr = 1'b0; t.addr = 8'h33; t.wdata = 32'h0;
        t.waits = 0; t.err = 1'b0; t.rdata = 32'h0; t.b2b = 1'b0;
        present(t);
        @(negedge pclk);
        trans_i = 1'b0;
        @(negedge pclk);
        check("pre_reset_access", {pselx, penable}, 2'b11);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        m_rdata = '0;
        m_wdata = '0;
        check("mid_reset_bus", {pselx, penable}, 2'b00);

        for (int i = 0; i < 40; i++) begin
            add(1'($urandom), 8'($urandom), $urandom,
                int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
                $urandom, 1'($urandom));
        end
        run_list();

`ifdef APB_TIMEOUT_EN
        @(negedge pclk);
        t.wr = 1'b0; t.addr = 8'h44; t.wdata = 32'h0;
        t.waits = 0; t.err = 1'b1; t.rdata = 32'h0; t.b2b = 1'b0;
        present(t);
        push_exp(t, 1'b1);
        @(negedge pclk);
        trans_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            if (penable) acc++;
            else if (!pselx) break;
        end
        check("timeout_len", 64'(acc), 64'd16);
`else
        acc = 0;
`endif

        repeat (3) @(negedge pclk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
